// File: rtl/dbuf_pkg.sv
// Shared types and sizing helpers for the double-buffered frame store.
package dbuf_pkg;

  // Number of bits needed to select one of the two banks.
  localparam int unsigned BANK_W = 1;

  // Controller states: normal operation, or zero-filling the back bank.
  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // Words per bank for a given address width.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/dbuf_bank_mem.sv
// Simple dual-port RAM holding both banks: one write port, one registered read port.
module dbuf_bank_mem
  import dbuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int unsigned WORDS = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage array; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Output register: loads on a read strobe, otherwise holds its last value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbuf_frame_ram.sv
// Ping-pong frame store: writer fills the back bank, scanner reads the front bank,
// banks exchange on a request/ack handshake, optional zero-fill of the new back bank.
module dbuf_frame_ram
  import dbuf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter bit          AUTO_CLEAR = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] WrAddr,
  input  logic [DATA_WIDTH-1:0] WrData,
  input  logic                  RdEn,
  input  logic [ADDR_WIDTH-1:0] RdAddr,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  RdValid,
  input  logic                  SwapReq,
  output logic                  SwapAck,
  output logic                  Busy,
  output logic                  WrDropped,
  output logic                  FrontBank
);

  localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
  localparam int unsigned PA_W  = BANK_W + ADDR_WIDTH;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  front_q, front_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic                  drop_q, drop_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  mem_we_c;
  logic [PA_W-1:0]       mem_waddr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic [PA_W-1:0]       mem_raddr_c;

  // Next-state, swap handshake and write-port steering.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    front_d     = front_q;
    ack_d       = 1'b0;
    drop_d      = drop_q;
    rd_valid_d  = RdEn;
    mem_we_c    = 1'b0;
    mem_waddr_c = {~front_q, WrAddr};
    mem_wdata_c = WrData;

    case (state_q)
      IDLE: begin
        // Writes target the pre-swap back bank even on the swap edge.
        mem_we_c = WrEn;
        if (SwapReq) begin
          front_d = ~front_q;
          ack_d   = 1'b1;
          if (AUTO_CLEAR) begin
            state_d = CLEAR;
            cnt_d   = '0;
          end
        end
      end
      CLEAR: begin
        // Clear owns the write port; external writes are discarded and flagged.
        mem_we_c    = 1'b1;
        mem_waddr_c = {~front_q, cnt_q};
        mem_wdata_c = '0;
        if (WrEn) begin
          drop_d = 1'b1;
        end
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CLEAR);

    // A reset edge must not disturb memory, including an in-flight clear write.
    if (!Reset) begin
      mem_we_c = 1'b0;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      front_q    <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      front_q    <= front_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Reads always come from the current (pre-swap) front bank.
  assign mem_raddr_c = {front_q, RdAddr};

  dbuf_bank_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (PA_W)
  ) u_mem (
    .clk     (Clock),
    .rst_n   (Reset),
    .we_i    (mem_we_c),
    .waddr_i (mem_waddr_c),
    .wdata_i (mem_wdata_c),
    .re_i    (RdEn),
    .raddr_i (mem_raddr_c),
    .rdata_o (RdData)
  );

  assign RdValid   = rd_valid_q;
  assign SwapAck   = ack_q;
  assign Busy      = busy_q;
  assign WrDropped = drop_q;
  assign FrontBank = front_q;

endmodule

// File: tb/tb_dbuf_frame_ram.sv
// Bench for dbuf_frame_ram: one auto-clear instance and one no-clear instance
// driven with identical inputs, each compared every cycle against its own array model.
module tb_dbuf_frame_ram;

  localparam int unsigned DW    = 2;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, wr_en, rd_en, swap_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data;

  logic [1:0][DW-1:0] rd_data;
  logic [1:0]         rd_valid, swap_ack, busy, wr_dropped, front_bank;

  // Instance 0 zero-fills after each swap, instance 1 does not.
  dbuf_frame_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AUTO_CLEAR(1'b1)) u_dut_clr (
    .Clock(clk), .Reset(rst_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdEn(rd_en), .RdAddr(rd_addr), .RdData(rd_data[0]), .RdValid(rd_valid[0]),
    .SwapReq(swap_req), .SwapAck(swap_ack[0]), .Busy(busy[0]),
    .WrDropped(wr_dropped[0]), .FrontBank(front_bank[0])
  );

  dbuf_frame_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AUTO_CLEAR(1'b0)) u_dut_nc (
    .Clock(clk), .Reset(rst_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .RdEn(rd_en), .RdAddr(rd_addr), .RdData(rd_data[1]), .RdValid(rd_valid[1]),
    .SwapReq(swap_req), .SwapAck(swap_ack[1]), .Busy(busy[1]),
    .WrDropped(wr_dropped[1]), .FrontBank(front_bank[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: two banks per instance, a clear countdown, and output state.
  int m_mem   [2][2][DEPTH];
  bit m_known [2][2][DEPTH];
  int m_front [2];
  int m_cnt   [2];
  int m_rdata [2];
  bit m_rknown[2];
  bit m_rvalid[2];
  bit m_ack   [2];
  bit m_drop  [2];
  bit m_clearing[2];

  function automatic void model_step(input int d, input bit auto_clr);
    int back;
    if (!rst_n) begin
      m_rdata[d] = 0;  m_rknown[d] = 1'b1; m_rvalid[d] = 1'b0; m_ack[d] = 1'b0;
      m_drop[d]  = 1'b0; m_front[d] = 0;   m_clearing[d] = 1'b0; m_cnt[d] = 0;
      return;
    end
    if (rd_en) begin
      m_rdata[d]  = m_mem[d][m_front[d]][rd_addr];
      m_rknown[d] = m_known[d][m_front[d]][rd_addr];
    end
    m_rvalid[d] = rd_en;
    m_ack[d]    = 1'b0;
    back        = 1 - m_front[d];
    if (m_clearing[d]) begin
      m_mem[d][back][m_cnt[d]]   = 0;
      m_known[d][back][m_cnt[d]] = 1'b1;
      if (wr_en) m_drop[d] = 1'b1;
      m_cnt[d]++;
      if (m_cnt[d] == DEPTH) m_clearing[d] = 1'b0;
    end else begin
      if (wr_en) begin
        m_mem[d][back][wr_addr]   = int'(wr_data);
        m_known[d][back][wr_addr] = 1'b1;
      end
      if (swap_req) begin
        m_front[d] = back;
        m_ack[d]   = 1'b1;
        if (auto_clr) begin
          m_clearing[d] = 1'b1;
          m_cnt[d]      = 0;
        end
      end
    end
  endfunction

  // Advance one clock, update both models, then compare every output.
  task automatic tick();
    @(posedge clk);
    model_step(0, 1'b1);
    model_step(1, 1'b0);
    #1;
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("d%0d_rd_valid", d), int'(rd_valid[d]), int'(m_rvalid[d]));
      check_eq($sformatf("d%0d_swap_ack", d), int'(swap_ack[d]), int'(m_ack[d]));
      check_eq($sformatf("d%0d_busy", d), int'(busy[d]), int'(m_clearing[d]));
      check_eq($sformatf("d%0d_wr_dropped", d), int'(wr_dropped[d]), int'(m_drop[d]));
      check_eq($sformatf("d%0d_front_bank", d), int'(front_bank[d]), m_front[d]);
      if (m_rknown[d])
        check_eq($sformatf("d%0d_rd_data", d), int'(rd_data[d]), m_rdata[d]);
    end
  endtask

  task automatic do_write(input int a, input int v);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(v);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_read(input int a);
    rd_en = 1'b1; rd_addr = AW'(a);
    tick();
    rd_en = 1'b0;
  endtask

  function automatic int pat(input int a);
    return (a % 3) + 1;
  endfunction

  initial begin
    int bcnt, first_ack, second_ack, acks;
    int exp_rd[3];
    int exp_fb[3];

    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; swap_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
    tick(); tick();
    rst_n = 1'b1;

    // Bring both banks of both instances to known contents.
    for (int a = 0; a < DEPTH; a++) do_write(a, int'($urandom_range(0, 3)));
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (DEPTH + 1) tick();
    for (int a = 0; a < DEPTH; a++) do_write(a, 0);
    rst_n = 1'b0; tick(); rst_n = 1'b1;

    // Back-bank write does not show in the front bank.
    do_write(5, 3);
    do_read(5);
    check_eq("tp1_rd_data", int'(rd_data[0]), 0);
    check_eq("tp1_rd_valid", int'(rd_valid[0]), 1);
    tick();
    check_eq("tp1_rd_valid_drop", int'(rd_valid[0]), 0);

    // Swap exposes the written word; clear runs exactly DEPTH cycles and drops writes.
    do_write(7, 2);
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    check_eq("tp2_ack", int'(swap_ack[0]), 1);
    check_eq("tp2_front", int'(front_bank[0]), 1);
    bcnt = 0;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (busy[0]) bcnt++;
      wr_en = (i == 3); wr_addr = AW'(7); wr_data = DW'(1);
      rd_en = (i == 0); rd_addr = AW'(7);
      tick();
      if (i == 0) check_eq("tp2_rd_data", int'(rd_data[0]), 2);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check_eq("tp3_busy_cycles", bcnt, DEPTH);
    check_eq("tp3_wr_dropped", int'(wr_dropped[0]), 1);
    check_eq("tp3_no_drop_nc", int'(wr_dropped[1]), 0);

    // Previously cleared bank reads all zero after the next swap.
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a);
      check_eq($sformatf("tp3_zero_a%0d", a), int'(rd_data[0]), 0);
    end
    repeat (2) tick();

    // Held request: second ack only after the clear has finished.
    first_ack = -1; second_ack = -1;
    swap_req = 1'b1;
    for (int i = 0; i < DEPTH + 6; i++) begin
      tick();
      if (swap_ack[0]) begin
        if (first_ack < 0) first_ack = i;
        else if (second_ack < 0) second_ack = i;
      end
    end
    swap_req = 1'b0;
    check_eq("tp4_ack_spacing", second_ack - first_ack, DEPTH + 1);
    repeat (DEPTH) tick();

    // Reset in the middle of a clear leaves a partially cleared bank.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (DEPTH + 1) tick();
    for (int a = 0; a < DEPTH; a++) do_write(a, pat(a));
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    swap_req = 1'b1; tick(); swap_req = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_eq("tp5_busy", int'(busy[0]), 0);
    check_eq("tp5_front", int'(front_bank[0]), 0);
    check_eq("tp5_ack", int'(swap_ack[0]), 0);
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a);
      check_eq($sformatf("tp5_a%0d", a), int'(rd_data[0]), (a < 6) ? 0 : pat(a));
    end

    // No-clear instance: back-to-back swaps, reads use the pre-swap bank.
    do_write(9, 3);
    exp_rd[0] = pat(9); exp_rd[1] = 3; exp_rd[2] = pat(9);
    exp_fb[0] = 1; exp_fb[1] = 0; exp_fb[2] = 1;
    acks = 0;
    swap_req = 1'b1; rd_en = 1'b1; rd_addr = AW'(9);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (swap_ack[1]) acks++;
      check_eq($sformatf("tp6_front_%0d", i), int'(front_bank[1]), exp_fb[i]);
      check_eq($sformatf("tp6_rd_%0d", i), int'(rd_data[1]), exp_rd[i]);
    end
    swap_req = 1'b0; rd_en = 1'b0;
    tick();
    check_eq("tp6_ack_count", acks, 3);
    check_eq("tp6_ack_drop", int'(swap_ack[1]), 0);

    // Randomised traffic, including occasional resets.
    for (int i = 0; i < 600; i++) begin
      rst_n    = ($urandom_range(0, 149) != 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom_range(0, DEPTH - 1));
      wr_data  = DW'($urandom_range(0, 3));
      rd_en    = 1'($urandom_range(0, 1));
      rd_addr  = AW'($urandom_range(0, DEPTH - 1));
      swap_req = ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dbuf_frame_ram.md
Name: dbuf_frame_ram

Overview:
- Parametrised, double-buffered (ping-pong) frame store for the LED display pipeline.
- Generalises the fixed 2-bit x 2048 single-bank pixel RAM:
  - data width and depth are parameters;
  - it holds two banks: the writer (UART/command side) fills the back bank while the scan/PWM side reads the front bank;
  - banks swap only on a handshake;
  - an optional zero-fill engine clears the new back bank after each swap.
- Single clock domain, placed between the command decoder and the row scanner.

Parameters:
DATA_WIDTH, 2, bits per memory word (pixel sub-channel slice)
ADDR_WIDTH, 11, address bits per bank; DEPTH = 2**ADDR_WIDTH
AUTO_CLEAR, 1, 1 = zero-fill new back bank after every swap; 0 = no fill

Ports:
Clock  input  1  system clock; all logic on rising edge
Reset  input  1  synchronous, active-low reset
WrEn  input  1  write strobe into back bank
WrAddr  input  ADDR_WIDTH  write address
WrData  input  DATA_WIDTH  write data
RdEn  input  1  read strobe from front bank
RdAddr  input  ADDR_WIDTH  read address
RdData  output  DATA_WIDTH  registered read data
RdValid  output  1  RdData valid this cycle
SwapReq  input  1  level request to exchange banks
SwapAck  output  1  one-cycle pulse: swap performed
Busy  output  1  clear engine running
WrDropped  output  1  sticky: a write was discarded while Busy
FrontBank  output  1  index of bank currently read

Behaviour:
- Reset:
  - Reset=0 sampled on a Clock edge forces RdData=0, RdValid=0, SwapAck=0, Busy=0, WrDropped=0, FrontBank=0, FSM=IDLE, clear counter=0.
  - Memory contents are not reset.
  - Reset mid-CLEAR aborts the fill; the partially cleared bank keeps its mixed contents.
- Storage:
  - 2*DEPTH words x DATA_WIDTH.
  - Physical address = {bank, addr}.
  - Back bank = ~FrontBank.
- Read path:
  - RdEn at edge N: front bank at RdAddr is sampled at N.
  - RdData/RdValid update at edge N+1 (latency 1).
  - RdValid=0 in any cycle following RdEn=0; RdData holds its last value.
  - A read issued on the same edge as a swap uses the pre-swap FrontBank.
- Write path:
  - WrEn with FSM=IDLE writes WrData to the back bank at WrAddr on that edge.
  - A write on the swap edge lands in the pre-swap back bank.
- FSM states: IDLE, CLEAR.
  - IDLE:
    - If SwapReq=1: FrontBank toggles, SwapAck=1 for exactly one cycle.
    - Then, if AUTO_CLEAR=1: enter CLEAR with counter=0, Busy=1 from the next cycle.
    - If SwapReq is still high after the ack, a further swap occurs only once the FSM is back in IDLE; there is no double-swap in consecutive cycles unless AUTO_CLEAR=0.
  - CLEAR:
    - Each cycle writes 0 to back[counter], then counter+1.
    - At counter=DEPTH-1: write, then return to IDLE and drop Busy.
    - CLEAR lasts exactly DEPTH cycles.
    - SwapReq is ignored (held off, not lost) while in CLEAR.
    - External WrEn is discarded and sets WrDropped=1, which stays set until Reset.
    - Reads are unaffected.
- With AUTO_CLEAR=0, back-to-back swaps are permitted: one per cycle while SwapReq=1, with an ack each cycle.
- Counter:
  - ADDR_WIDTH bits, wraps naturally.
  - Termination uses an explicit compare to DEPTH-1, not overflow.
- Simultaneous WrEn and clear write to the same address: the clear wins and the write is dropped.

Decomposition:
- Shared package (dbuf_pkg): state enum {IDLE, CLEAR}, DEPTH function of ADDR_WIDTH, bank-index width constant.
- One natural sub-module: dbuf_bank_mem.
  - Simple dual-port, one write and one registered read, width DATA_WIDTH, depth 2*DEPTH.
  - Infers block RAM; a wrapper for hard RAM primitives is allowed behind it.
- The FSM, swap and mux logic lives in the top.

Test Plan:
- Reset, then write 0x3 at back addr 5 and read front addr 5 → RdData=0 (front untouched) one cycle after RdEn, RdValid=1 for one cycle.
- Write 0x2 at addr 7, pulse SwapReq → SwapAck one cycle, FrontBank=1; read addr 7 → RdData=0x2 at latency 1.
- AUTO_CLEAR=1, ADDR_WIDTH=4:
  - After the swap, Busy=1 for exactly 16 cycles.
  - WrEn during Busy → WrDropped=1.
  - After Busy falls, the back bank reads all 0 on the next swap.
- SwapReq held high through CLEAR → second SwapAck is asserted on the first cycle after Busy falls, never earlier.
- Reset asserted at clear counter=6 → next cycle Busy=0, FrontBank=0, SwapAck=0; addresses 0-5 are 0 and 6+ retain old data.
- AUTO_CLEAR=0, SwapReq high for 3 cycles → 3 SwapAck pulses, FrontBank toggles 0→1→0→1; a read issued on the swap edge returns pre-swap bank data.
